qspi_sync_fifo: RTL and testbench

//  Parametrised single-clock FIFO for the QSPI controller's AHB<->QSPI data paths (TX/RX buffering).

---
 rtl/qspi_sync_fifo_if.sv | 40 ++++
 rtl/qspi_sync_fifo.sv | 109 ++++++++++
 tb/tb_qspi_sync_fifo.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/qspi_sync_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : qspi_sync_fifo_if                                        |
// | Brief   : Handshake/status bundle for the QSPI single-clock FIFO   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface qspi_sync_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
);
  localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [c_LVL_W-1:0]    level;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;

  modport master (
    output flush, wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/qspi_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : qspi_sync_fifo                                           |
// | Brief   : Single-clock FIFO with level, thresholds, flush, sticky  |
// |           errors. Define QSPI_FIFO_FWFT_EN for fall-through read.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module qspi_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4
) (
  input wire logic         clk,
  input wire logic         rst,
  qspi_sync_fifo_if.slave  bus
);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_LVL_W-1:0]    r_level;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full   = (r_level == c_LVL_W'(FIFO_DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_wr_acc = bus.wr_en & ~w_full  & ~bus.flush;
  assign w_rd_acc = bus.rd_en & ~w_empty & ~bus.flush;

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_level >= c_LVL_W'(AF_THRESH));
  assign bus.almost_empty = (r_level <= c_LVL_W'(AE_THRESH));
  assign bus.level        = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  // Storage is deliberately left out of reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A set event in the same cycle as err_clr must win, so set is applied last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      if (bus.wr_en & w_full & ~bus.flush)  r_overflow  <= 1'b1;
      if (bus.rd_en & w_empty & ~bus.flush) r_underflow <= 1'b1;
    end
  end

`ifdef QSPI_FIFO_FWFT_EN
  assign bus.rd_data  = r_mem[r_rd_ptr];
  assign bus.rd_valid = ~w_empty;
`else
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
`endif
endmodule
`default_nettype wire

// File: tb/tb_qspi_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_qspi_sync_fifo                                        |
// | Brief   : Directed + random bench with queue reference model       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_qspi_sync_fifo;
  localparam int c_DW    = 32;
  localparam int c_DEPTH = 16;
  localparam int c_AF    = 12;
  localparam int c_AE    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qspi_sync_fifo_if #(.DATA_WIDTH(c_DW), .FIFO_DEPTH(c_DEPTH)) bus ();

  qspi_sync_fifo #(
    .DATA_WIDTH(c_DW), .FIFO_DEPTH(c_DEPTH), .AF_THRESH(c_AF), .AE_THRESH(c_AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [c_DW-1:0] model[$];
  logic [c_DW-1:0] m_data;
  bit              m_valid;
  bit              m_ovf;
  bit              m_unf;
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("level", 32'(bus.level), 32'(model.size()));
    check("full", 32'(bus.full), 32'(model.size() == c_DEPTH));
    check("empty", 32'(bus.empty), 32'(model.size() == 0));
    check("almost_full", 32'(bus.almost_full), 32'(model.size() >= c_AF));
    check("almost_empty", 32'(bus.almost_empty), 32'(model.size() <= c_AE));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("underflow", 32'(bus.underflow), 32'(m_unf));
`ifdef QSPI_FIFO_FWFT_EN
    check("rd_valid", 32'(bus.rd_valid), 32'(model.size() != 0));
    if (model.size() != 0) check("rd_data", bus.rd_data, model[0]);
`else
    check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
    check("rd_data", bus.rd_data, m_data);
`endif
  endtask

  // One clock: drive inputs at negedge, advance the model, check 1ns after posedge.
  task automatic step(input bit r, input bit f, input bit w, input logic [c_DW-1:0] wd,
                      input bit rd, input bit ec);
    bit fm;
    bit em;
    @(negedge clk);
    rst = r; bus.flush = f; bus.wr_en = w; bus.wr_data = wd; bus.rd_en = rd; bus.err_clr = ec;
    fm = (model.size() == c_DEPTH);
    em = (model.size() == 0);
    if (r) begin
      model.delete(); m_data = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (ec) begin m_ovf = 0; m_unf = 0; end
      if (w && fm && !f) m_ovf = 1;
      if (rd && em && !f) m_unf = 1;
      m_valid = 0;
      if (f) begin
        model.delete();
      end else begin
        if (rd && !em) begin m_data = model.pop_front(); m_valid = 1; end
        if (w && !fm) model.push_back(wd);
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    bus.flush = 0; bus.wr_en = 0; bus.wr_data = '0; bus.rd_en = 0; bus.err_clr = 0;
    m_data = '0; m_valid = 0; m_ovf = 0; m_unf = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);

    // Fill with 0xA0..0xAF, overflow on 17th, then drain in order
    for (int i = 0; i < 16; i++) step(0, 0, 1, 32'hA0 + 32'(i), 0, 0);
    check("fill_level", 32'(bus.level), 32'd16);
    step(0, 0, 1, 32'hDEAD, 0, 0);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 0, 1, 0);
      check("drain_word", bus.rd_data, 32'hA0 + 32'(i));
    end

    // Level held at 3 across pointer wrap
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h300 + 32'(i), 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 1, 32'h400 + 32'(i), 1, 0);
    check("hold_level", 32'(bus.level), 32'd3);

    // Simultaneous at full, then at empty
    step(0, 0, 0, 0, 0, 1);
    while (model.size() < c_DEPTH) step(0, 0, 1, $urandom, 0, 0);
    step(0, 0, 1, 32'h1234, 1, 0);
    check("full_both_level", 32'(bus.level), 32'd15);
    step(0, 0, 0, 0, 0, 1);
    while (model.size() > 0) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 32'h5555, 1, 0);
    check("empty_both_level", 32'(bus.level), 32'd1);
    check("empty_both_unf", 32'(bus.underflow), 32'd1);

    // Flush at level 9 with concurrent wr/rd
    while (model.size() < 9) step(0, 0, 1, $urandom, 0, 0);
    step(0, 1, 1, 32'hBAD, 1, 0);
    check("flush_empty", 32'(bus.empty), 32'd1);
    step(0, 0, 0, 0, 0, 0);

    // err_clr alone, then err_clr colliding with a set event
    while (model.size() < c_DEPTH) step(0, 0, 1, $urandom, 0, 0);
    step(0, 0, 1, 32'h1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("ovf_cleared", 32'(bus.overflow), 32'd0);
    step(0, 0, 1, 32'h2, 0, 1);
    check("ovf_clr_collide", 32'(bus.overflow), 32'd1);

    // Randomized traffic, including rare flush/err_clr and a mid-run reset
    for (int i = 0; i < 400; i++) begin
      step(i == 200, ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 1) == 1, ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
